// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: field widths, the assembled
// instruction record held in the fetch FIFO, and the word-pair phase.
package fetch_pkg;

    localparam int OP_W  = 8;
    localparam int REG_W = 8;
    localparam int ARG_W = 16;
    // Widest supported program-memory address; narrower PCs are zero-padded.
    localparam int PC_W  = 16;

    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [REG_W-1:0] reg_num;
        logic [ARG_W-1:0] arg;
        logic [PC_W-1:0]  pc;
    } inst_t;

    typedef enum logic {
        PH_HI,
        PH_LO
    } phase_t;

endpackage

// File: rtl/inst_fifo.sv
// Register-based instruction FIFO between fetch and decode. Flush wins over
// push/pop; a pushed entry becomes visible at the head the cycle after.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clka,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  inst_t            push_data,
    output logic [CNT_W-1:0] count,
    output inst_t            head
);

    localparam int PTR_W = $clog2(DEPTH);

    inst_t            entries [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;

    assign pop_ok = pop && (count != '0);
    assign head   = entries[rd_ptr];

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Fetch credits keep the FIFO from ever overflowing.
            if (push && !pop_ok) begin
                assert (count < CNT_W'(DEPTH));
            end
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop_ok) begin
                count <= count + CNT_W'(1);
            end else if (pop_ok && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: reads 2-word instructions from program memory, assembles them
// and queues them for decode; a redirect flushes everything and restarts.
module inst_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clka,
    input  logic              rst,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [OP_W-1:0]   inst_op,
    output logic [REG_W-1:0]  inst_reg,
    output logic [ARG_W-1:0]  inst_arg,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    phase_t            phase;
    phase_t            req_phase;
    phase_t            rsp_phase;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_valid;
    logic [CNT_W-1:0]  pending;
    logic [CNT_W-1:0]  fifo_count;
    logic              half_valid;
    logic [OP_W-1:0]   half_op;
    logic [REG_W-1:0]  half_reg;
    logic [ADDR_W-1:0] half_pc;
    logic              credit_ok;
    logic              issue_hi;
    logic              push;
    logic              pop;
    inst_t             push_data;
    inst_t             head;

    always_comb begin
        credit_ok = ({1'b0, fifo_count} + {1'b0, pending}) < (CNT_W + 1)'(DEPTH);
        issue_hi  = (phase == PH_HI) && credit_ok;
        push      = rsp_valid && (rsp_phase == PH_LO) && half_valid;
        pop       = inst_valid && inst_ready;
        push_data         = '0;
        push_data.op      = half_op;
        push_data.reg_num = half_reg;
        push_data.arg     = ARG_W'(mem_dout);
        push_data.pc      = PC_W'(half_pc);
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            phase      <= PH_HI;
            pc         <= '0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            req_phase  <= PH_HI;
            rsp_valid  <= 1'b0;
            rsp_phase  <= PH_HI;
            rsp_addr   <= '0;
            pending    <= '0;
            half_valid <= 1'b0;
            half_op    <= '0;
            half_reg   <= '0;
            half_pc    <= '0;
        end else if (redirect_valid) begin
            // Everything is flushed, so word0 of the target is issued at this
            // same edge; that keeps the first new push three edges away.
            phase      <= PH_LO;
            pc         <= redirect_pc + ADDR_W'(1);
            mem_en     <= 1'b1;
            mem_addr   <= redirect_pc;
            req_phase  <= PH_HI;
            rsp_valid  <= 1'b0;
            pending    <= CNT_W'(1);
            half_valid <= 1'b0;
        end else begin
            rsp_valid <= mem_en;
            rsp_phase <= req_phase;
            rsp_addr  <= mem_addr;

            if (phase == PH_LO) begin
                mem_en    <= 1'b1;
                mem_addr  <= pc;
                req_phase <= PH_LO;
                pc        <= pc + ADDR_W'(1);
                phase     <= PH_HI;
            end else if (credit_ok) begin
                mem_en    <= 1'b1;
                mem_addr  <= pc;
                req_phase <= PH_HI;
                pc        <= pc + ADDR_W'(1);
                phase     <= PH_LO;
            end else begin
                mem_en <= 1'b0;
            end

            if (rsp_valid && (rsp_phase == PH_HI)) begin
                half_valid <= 1'b1;
                half_op    <= mem_dout[OP_W+REG_W-1:REG_W];
                half_reg   <= mem_dout[REG_W-1:0];
                half_pc    <= rsp_addr;
            end else if (push) begin
                half_valid <= 1'b0;
            end

            pending <= pending + CNT_W'(issue_hi) - CNT_W'(push);
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clka      (clka),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .count     (fifo_count),
        .head      (head)
    );

    assign inst_valid = (fifo_count != '0);
    assign inst_op    = head.op;
    assign inst_reg   = head.reg_num;
    assign inst_arg   = head.arg;
    assign inst_pc    = head.pc[ADDR_W-1:0];

    if (ADDR_W < PC_W) begin : g_pc_pad
        logic unused_pc_hi;
        assign unused_pc_hi = ^head.pc[PC_W-1:ADDR_W];
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit with a 1-cycle-latency program memory
// model; expected values are hand-derived edge counts from reset/redirect.
module tb_inst_fetch_unit;

    logic        clka;
    logic        rst;
    logic        mem_en;
    logic [9:0]  mem_addr;
    logic [15:0] mem_dout;
    logic        redirect_valid;
    logic [9:0]  redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [7:0]  inst_op;
    logic [7:0]  inst_reg;
    logic [15:0] inst_arg;
    logic [9:0]  inst_pc;

    logic [15:0] mem [1024];
    int checks   = 0;
    int failures = 0;

    inst_fetch_unit #(
        .ADDR_W (10),
        .DATA_W (16),
        .DEPTH  (4)
    ) dut (
        .clka           (clka),
        .rst            (rst),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_dout       (mem_dout),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_op        (inst_op),
        .inst_reg       (inst_reg),
        .inst_arg       (inst_arg),
        .inst_pc        (inst_pc)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial mem_dout = '0;
    always @(posedge clka) begin
        if (mem_en) mem_dout <= mem[mem_addr];
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clka);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [9:0] rpc, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Head must hold the instruction whose word0 sits at address p.
    task automatic checkInst(input string tag, input int p);
        checkOutput({tag, "_valid"}, 32'(inst_valid), 32'd1);
        checkOutput({tag, "_op"},    32'(inst_op),    32'(mem[p % 1024][15:8]));
        checkOutput({tag, "_reg"},   32'(inst_reg),   32'(mem[p % 1024][7:0]));
        checkOutput({tag, "_arg"},   32'(inst_arg),   32'(mem[(p + 1) % 1024]));
        checkOutput({tag, "_pc"},    32'(inst_pc),    32'(p % 1024));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_mem_en"},   32'(mem_en),     32'd0);
        checkOutput({tag, "_mem_addr"}, 32'(mem_addr),   32'd0);
        checkOutput({tag, "_valid"},    32'(inst_valid), 32'd0);
        checkOutput({tag, "_op"},       32'(inst_op),    32'd0);
        checkOutput({tag, "_reg"},      32'(inst_reg),   32'd0);
        checkOutput({tag, "_arg"},      32'(inst_arg),   32'd0);
        checkOutput({tag, "_pc"},       32'(inst_pc),    32'd0);
    endtask

    // Leaves rst released just after an edge, so the next edge is edge 1.
    task automatic doReset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'(i * 291 + 257);
        mem[0] = 16'h0401;
        mem[1] = 16'h0005;
        mem[2] = 16'h0502;
        mem[3] = 16'h0003;

        rst = 1'b0;
        applyStimulus(1'b0, 10'h000, 1'b0);
        tick(2);
        checkIdle("reset");

        // Basic streaming from reset with decode always ready.
        rst = 1'b1;
        inst_ready = 1'b1;
        tick(1);
        checkOutput("e1_mem_en", 32'(mem_en), 32'd1);
        checkOutput("e1_mem_addr", 32'(mem_addr), 32'd0);
        tick(1);
        checkOutput("e2_mem_addr", 32'(mem_addr), 32'd1);
        tick(1);
        checkOutput("e3_valid", 32'(inst_valid), 32'd0);
        tick(1);
        checkOutput("e4_valid", 32'(inst_valid), 32'd1);
        checkOutput("e4_op", 32'(inst_op), 32'h04);
        checkOutput("e4_reg", 32'(inst_reg), 32'h01);
        checkOutput("e4_arg", 32'(inst_arg), 32'h0005);
        checkOutput("e4_pc", 32'(inst_pc), 32'h000);
        tick(1);
        checkOutput("e5_valid", 32'(inst_valid), 32'd0);
        tick(1);
        checkOutput("e6_op", 32'(inst_op), 32'h05);
        checkOutput("e6_reg", 32'(inst_reg), 32'h02);
        checkOutput("e6_arg", 32'(inst_arg), 32'h0003);
        checkOutput("e6_pc", 32'(inst_pc), 32'h002);

        // Decode stalled: four instructions fill the FIFO, then fetch stops.
        inst_ready = 1'b0;
        doReset();
        tick(8);
        checkOutput("stall_e8_mem_en", 32'(mem_en), 32'd1);
        checkOutput("stall_e8_mem_addr", 32'(mem_addr), 32'd7);
        tick(1);
        checkOutput("stall_e9_mem_en", 32'(mem_en), 32'd0);
        tick(1);
        checkInst("stall_e10", 0);
        tick(4);
        checkOutput("stall_e14_mem_en", 32'(mem_en), 32'd0);
        checkInst("stall_e14", 0);
        inst_ready = 1'b1;
        tick(1);
        checkOutput("stall_e15_mem_en", 32'(mem_en), 32'd0);
        checkInst("stall_e15", 2);
        tick(1);
        checkOutput("stall_e16_mem_en", 32'(mem_en), 32'd1);
        checkOutput("stall_e16_mem_addr", 32'(mem_addr), 32'd8);
        checkInst("stall_e16", 4);
        tick(2);
        checkOutput("stall_e18_valid", 32'(inst_valid), 32'd0);
        tick(1);
        checkInst("stall_e19", 8);

        // Redirect with 3 queued and a LO response arriving at the same edge.
        inst_ready = 1'b0;
        doReset();
        tick(9);
        checkInst("redir_pre", 0);
        applyStimulus(1'b1, 10'h100, 1'b0);
        tick(1);
        applyStimulus(1'b0, 10'h000, 1'b1);
        checkOutput("redir_r0_valid", 32'(inst_valid), 32'd0);
        checkOutput("redir_r0_mem_en", 32'(mem_en), 32'd1);
        checkOutput("redir_r0_mem_addr", 32'(mem_addr), 32'h100);
        tick(1);
        checkOutput("redir_r1_mem_addr", 32'(mem_addr), 32'h101);
        checkOutput("redir_r1_valid", 32'(inst_valid), 32'd0);
        tick(1);
        checkOutput("redir_r2_valid", 32'(inst_valid), 32'd0);
        tick(1);
        checkInst("redir_r3", 32'h100);
        tick(1);
        checkOutput("redir_r4_valid", 32'(inst_valid), 32'd0);
        tick(1);
        checkInst("redir_r5", 32'h102);

        // Redirect on the same edge that decode accepts pc 0x006.
        inst_ready = 1'b1;
        doReset();
        tick(10);
        checkInst("poprd_pre", 6);
        applyStimulus(1'b1, 10'h040, 1'b1);
        tick(1);
        applyStimulus(1'b0, 10'h000, 1'b1);
        checkOutput("poprd_r0_valid", 32'(inst_valid), 32'd0);
        checkOutput("poprd_r0_mem_addr", 32'(mem_addr), 32'h040);
        tick(1);
        checkOutput("poprd_r1_valid", 32'(inst_valid), 32'd0);
        tick(2);
        checkInst("poprd_r3", 32'h040);

        // Instruction straddling the PC wrap.
        applyStimulus(1'b1, 10'h3FF, 1'b1);
        tick(1);
        applyStimulus(1'b0, 10'h000, 1'b1);
        checkOutput("wrap_r0_mem_addr", 32'(mem_addr), 32'h3FF);
        tick(1);
        checkOutput("wrap_r1_mem_addr", 32'(mem_addr), 32'h000);
        tick(2);
        checkInst("wrap_r3", 32'h3FF);
        checkOutput("wrap_r3_arg_word0", 32'(inst_arg), 32'h0401);
        tick(2);
        checkInst("wrap_r5", 1);

        // Reset pulled mid-pair with instructions queued.
        inst_ready = 1'b0;
        doReset();
        tick(7);
        checkInst("rstmid_pre", 0);
        rst = 1'b0;
        #1;
        checkIdle("rstmid_async");
        tick(2);
        checkIdle("rstmid_hold");
        rst = 1'b1;
        inst_ready = 1'b1;
        tick(1);
        checkOutput("rstmid_e1_mem_en", 32'(mem_en), 32'd1);
        checkOutput("rstmid_e1_mem_addr", 32'(mem_addr), 32'd0);
        tick(2);
        checkOutput("rstmid_e3_valid", 32'(inst_valid), 32'd0);
        tick(1);
        checkInst("rstmid_e4", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
